// File: rtl/dna_search_loader.sv
// dna_search_loader
//   Loader front-end for the comparator-based DNA search core. It takes an
//   ASCII nucleotide stream (key bases first, then reference bases) and
//   encodes each base to 2 bits, A=00 C=01 G=10 T=11, case-insensitive.
//   Bases are packed MSB-first into `key` and `data`. While loading it holds
//   the core in reset. It then releases the core for a bounded run window and
//   reports whether, and on which run cycle, the core raised `match`.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous active-high reset
//   in_valid       input byte valid
//   in_ready       loader can take a byte (state-only, independent of in_valid)
//   in_byte        ASCII character
//   data           packed reference bases, to search core `data`
//   key            packed key bases, to search core `key`
//   search_reset   to search core `reset`; low only while running
//   search_match   from search core `match`
//   done           job result valid; held until the next accepted byte
//   found          match seen in the run window (valid while done)
//   result_cycles  run cycle index of the match, or TIMEOUT_CYCLES on timeout
//   error          sticky: an illegal character was received
module dna_search_loader #(
  parameter int unsigned DATA_BASES     = 512,
  parameter int unsigned KEY_BASES      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_byte,
  output logic [2*DATA_BASES-1:0] data,
  output logic [2*KEY_BASES-1:0]  key,
  output logic                    search_reset,
  input  logic                    search_match,
  output logic                    done,
  output logic                    found,
  output logic [15:0]             result_cycles,
  output logic                    error
);

  localparam int unsigned DW   = 2 * DATA_BASES;
  localparam int unsigned KW   = 2 * KEY_BASES;
  localparam int unsigned MAXB = (KEY_BASES > DATA_BASES) ? KEY_BASES : DATA_BASES;
  localparam int unsigned CW   = $clog2(MAXB + 1);

  localparam logic [CW-1:0] KEY_LAST  = CW'(KEY_BASES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BASES - 1);
  localparam logic [15:0]   RUN_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   TIMEOUT_V = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_KEY  = 2'd0,
    S_DATA = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] base_cnt;
  logic [15:0]   run_cnt;

  logic [1:0] code;
  logic       is_base;
  logic       is_illegal;
  logic       accept;
  logic       store;
  logic [CW-1:0] key_pos;

  // Character decode. CR/LF are neither bases nor errors.
  always_comb begin
    code       = 2'b00;
    is_base    = 1'b0;
    is_illegal = 1'b0;
    case (in_byte)
      8'h41, 8'h61: begin code = 2'b00; is_base = 1'b1; end
      8'h43, 8'h63: begin code = 2'b01; is_base = 1'b1; end
      8'h47, 8'h67: begin code = 2'b10; is_base = 1'b1; end
      8'h54, 8'h74: begin code = 2'b11; is_base = 1'b1; end
      8'h0A, 8'h0D: ;
      default:      is_illegal = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign store  = accept && is_base;

  // A byte accepted in S_DONE starts a fresh key, so it is treated as key
  // position 0 regardless of the leftover counter value.
  assign key_pos = (state == S_DONE) ? '0 : base_cnt;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_KEY;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_KEY, S_DONE: begin
        if (store && key_pos == KEY_LAST) state_next = S_DATA;
        else if (accept)                  state_next = S_KEY;
      end
      S_DATA: begin
        if (store && base_cnt == DATA_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        if (search_match || run_cnt == RUN_LAST) state_next = S_DONE;
      end
      default: state_next = S_KEY;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready     = 1'b1;
    search_reset = 1'b1;
    done         = 1'b0;
    case (state)
      S_RUN: begin
        in_ready     = 1'b0;
        search_reset = 1'b0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: packing, counters, result capture, sticky error
  always_ff @(posedge clock) begin
    if (reset) begin
      key           <= '0;
      data          <= '0;
      base_cnt      <= '0;
      run_cnt       <= '0;
      found         <= 1'b0;
      result_cycles <= '0;
      error         <= 1'b0;
    end else begin
      if (accept && is_illegal) error <= 1'b1;

      case (state)
        S_KEY, S_DONE: begin
          if (state == S_DONE && accept) begin
            found         <= 1'b0;
            result_cycles <= '0;
            base_cnt      <= '0;
          end
          if (store) begin
            key      <= (key << 2) | KW'(code);
            base_cnt <= (key_pos == KEY_LAST) ? '0 : key_pos + 1'b1;
          end
        end
        S_DATA: begin
          if (store) begin
            data <= (data << 2) | DW'(code);
            if (base_cnt == DATA_LAST) begin
              base_cnt <= '0;
              run_cnt  <= '0;
            end else begin
              base_cnt <= base_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          // A match on the last run cycle wins over the timeout.
          if (search_match) begin
            found         <= 1'b1;
            result_cycles <= run_cnt;
          end else if (run_cnt == RUN_LAST) begin
            found         <= 1'b0;
            result_cycles <= TIMEOUT_V;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
